// File: rtl/whack_pkg.sv
// Shared types and defaults for the whack-a-mole button conditioning path.
package whack_pkg;

  typedef enum logic [1:0] {
    StReleased,
    StPressChk,
    StPressed,
    StReleaseChk
  } btn_state_t;

  localparam int unsigned DEBOUNCE_DEFAULT = 1000;
  localparam int unsigned CNT_W_DEFAULT    = 10;

endpackage

// File: rtl/whack_btn_debounce.sv
// One button channel: 2-flop synchroniser, saturating stability counter and debounce FSM.
// accept_o is a combinational strobe marking the cycle a press is accepted.
module whack_btn_debounce
  import whack_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic accept_o,
  output logic level_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  logic [1:0]       sync_q;
  logic             sync;
  btn_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             level_q;

  assign sync    = sync_q[1];
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_raw_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StReleased;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      unique case (state_q)
        StReleased: begin
          if (sync) begin
            state_q <= StPressChk;
            cnt_q   <= '0;
          end
        end
        StPressChk: begin
          cnt_q <= cnt_inc;
          if (!sync) begin
            state_q <= StReleased;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StPressed;
            level_q <= 1'b1;
          end
        end
        StPressed: begin
          if (!sync) begin
            state_q <= StReleaseChk;
            cnt_q   <= '0;
          end
        end
        StReleaseChk: begin
          cnt_q <= cnt_inc;
          if (sync) begin
            state_q <= StPressed;
          end else if (cnt_q == CntLast) begin
            state_q <= StReleased;
            level_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StReleased;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign accept_o = (state_q == StPressChk) && sync && (cnt_q == CntLast);
  assign level_o  = level_q;

endmodule

// File: rtl/whack_button_conditioner.sv
// Debounces N_BTN player buttons and emits one registered toggle pulse per accepted press.
// Define WHACK_SINGLE_HIT_EN to allow at most one pulse per cycle (lowest index wins).
module whack_button_conditioner
  import whack_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw_i,
  input  logic             enable_i,
  output logic [N_BTN-1:0] toggle_pulse_o,
  output logic [N_BTN-1:0] btn_level_o,
  output logic             any_pulse_o
);

  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] gated;
  logic [N_BTN-1:0] pulse_d;
  logic [N_BTN-1:0] pulse_q;
  logic             any_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    whack_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .btn_raw_i (btn_raw_i[i]),
      .accept_o  (accept[i]),
      .level_o   (btn_level_o[i])
    );
  end

  // Suppressed acceptances are dropped, not deferred.
  always_comb begin
    gated = accept & {N_BTN{enable_i}};
`ifdef WHACK_SINGLE_HIT_EN
    pulse_d = gated & (~gated + N_BTN'(1));
`else
    pulse_d = gated;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_q <= '0;
      any_q   <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      any_q   <= |pulse_d;
    end
  end

  assign toggle_pulse_o = pulse_q;
  assign any_pulse_o    = any_q;

endmodule

// File: tb/tb_whack_button_conditioner.sv
// Directed bench for whack_button_conditioner with DEBOUNCE_CYCLES=4 (press-to-pulse latency 7).
module tb_whack_button_conditioner;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] raw;
    logic [3:0] pulse;
    logic [3:0] level;
    logic       any;
    string      name;
  } vec_t;

`ifdef WHACK_SINGLE_HIT_EN
  localparam logic [3:0] SimulPulse = 4'b0010;
`else
  localparam logic [3:0] SimulPulse = 4'b1010;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic       enable;
  logic [3:0] toggle_pulse;
  logic [3:0] btn_level;
  logic       any_pulse;

  int   n_vec  = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  whack_button_conditioner #(
    .N_BTN           (4),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_raw_i      (btn_raw),
    .enable_i       (enable),
    .toggle_pulse_o (toggle_pulse),
    .btn_level_o    (btn_level),
    .any_pulse_o    (any_pulse)
  );

  // Append n identical cycles: inputs held, outputs expected after each clock edge.
  task automatic seg(input int n, input logic rst, input logic en, input logic [3:0] raw,
                     input logic [3:0] p, input logic [3:0] l, input string nm);
    vec_t v;
    v.rst   = rst;
    v.en    = en;
    v.raw   = raw;
    v.pulse = p;
    v.level = l;
    v.any   = |p;
    v.name  = nm;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [3:0] p, input logic [3:0] l, input logic a);
    n_vec++;
    if (toggle_pulse !== p || btn_level !== l || any_pulse !== a) begin
      n_fail++;
      $display("FAIL %s: got pulse=%b level=%b any=%b, want pulse=%b level=%b any=%b",
               nm, toggle_pulse, btn_level, any_pulse, p, l, a);
    end
  endtask

  initial begin
    int lat;
    bit seen;

    // reset
    seg(2, 1, 1, 4'b0000, 4'b0000, 4'b0000, "reset");
    // 1: clean press on btn0, then release
    seg(6, 0, 1, 4'b0001, 4'b0000, 4'b0000, "press0_wait");
    seg(1, 0, 1, 4'b0001, 4'b0001, 4'b0001, "press0_pulse");
    seg(4, 0, 1, 4'b0001, 4'b0000, 4'b0001, "press0_held");
    seg(6, 0, 1, 4'b0000, 4'b0000, 4'b0001, "release0_wait");
    seg(2, 0, 1, 4'b0000, 4'b0000, 4'b0000, "release0_done");
    // 2: bounce on btn1 before settling high
    seg(3, 0, 1, 4'b0010, 4'b0000, 4'b0000, "bounce1_hi");
    seg(1, 0, 1, 4'b0000, 4'b0000, 4'b0000, "bounce1_lo");
    seg(6, 0, 1, 4'b0010, 4'b0000, 4'b0000, "bounce1_wait");
    seg(1, 0, 1, 4'b0010, 4'b0010, 4'b0010, "bounce1_pulse");
    seg(3, 0, 1, 4'b0010, 4'b0000, 4'b0010, "bounce1_held");
    // 3: release bounce on btn1
    seg(2, 0, 1, 4'b0000, 4'b0000, 4'b0010, "relb_lo1");
    seg(2, 0, 1, 4'b0010, 4'b0000, 4'b0010, "relb_hi1");
    seg(2, 0, 1, 4'b0000, 4'b0000, 4'b0010, "relb_lo2");
    seg(2, 0, 1, 4'b0010, 4'b0000, 4'b0010, "relb_hi2");
    seg(6, 0, 1, 4'b0000, 4'b0000, 4'b0010, "relb_final");
    seg(2, 0, 1, 4'b0000, 4'b0000, 4'b0000, "relb_done");
    // 4: acceptance of btn2 while disabled is lost; next press pulses
    seg(6, 0, 0, 4'b0100, 4'b0000, 4'b0000, "dis2_wait");
    seg(2, 0, 0, 4'b0100, 4'b0000, 4'b0100, "dis2_nopulse");
    seg(6, 0, 1, 4'b0000, 4'b0000, 4'b0100, "dis2_release");
    seg(2, 0, 1, 4'b0000, 4'b0000, 4'b0000, "dis2_released");
    seg(6, 0, 1, 4'b0100, 4'b0000, 4'b0000, "en2_wait");
    seg(1, 0, 1, 4'b0100, 4'b0100, 4'b0100, "en2_pulse");
    seg(2, 0, 1, 4'b0100, 4'b0000, 4'b0100, "en2_held");
    seg(6, 0, 1, 4'b0000, 4'b0000, 4'b0100, "en2_release");
    seg(2, 0, 1, 4'b0000, 4'b0000, 4'b0000, "en2_released");
    // 5: simultaneous press of btn1 and btn3
    seg(6, 0, 1, 4'b1010, 4'b0000, 4'b0000, "simul_wait");
    seg(1, 0, 1, 4'b1010, SimulPulse, 4'b1010, "simul_pulse");
    seg(2, 0, 1, 4'b1010, 4'b0000, 4'b1010, "simul_held");
    seg(6, 0, 1, 4'b0000, 4'b0000, 4'b1010, "simul_release");
    seg(2, 0, 1, 4'b0000, 4'b0000, 4'b0000, "simul_released");
    // 6: reset at debounce count 2, then again while pressed
    seg(5, 0, 1, 4'b0001, 4'b0000, 4'b0000, "rst_pre");
    seg(1, 1, 1, 4'b0001, 4'b0000, 4'b0000, "rst_mid");
    seg(6, 0, 1, 4'b0001, 4'b0000, 4'b0000, "rst_wait");
    seg(1, 0, 1, 4'b0001, 4'b0001, 4'b0001, "rst_pulse");
    seg(3, 0, 1, 4'b0001, 4'b0000, 4'b0001, "rst_held");
    seg(1, 1, 1, 4'b0001, 4'b0000, 4'b0000, "rst_pressed");
    seg(6, 0, 1, 4'b0001, 4'b0000, 4'b0000, "rst2_wait");
    seg(1, 0, 1, 4'b0001, 4'b0001, 4'b0001, "rst2_pulse");
    seg(2, 0, 1, 4'b0001, 4'b0000, 4'b0001, "rst2_held");
    seg(6, 0, 1, 4'b0000, 4'b0000, 4'b0001, "rst2_release");
    seg(2, 0, 1, 4'b0000, 4'b0000, 4'b0000, "rst2_released");

    reset   = 1'b1;
    enable  = 1'b1;
    btn_raw = 4'b0000;
    foreach (vecs[i]) begin
      reset   = vecs[i].rst;
      enable  = vecs[i].en;
      btn_raw = vecs[i].raw;
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].pulse, vecs[i].level, vecs[i].any);
    end

    // Measured latency on btn3 with a bounded wait, then no repeat pulse while held.
    btn_raw = 4'b1000;
    lat     = 0;
    seen    = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (toggle_pulse != 4'b0000) seen = 1'b1;
    end
    n_vec++;
    if (!seen || lat != 7 || toggle_pulse !== 4'b1000) begin
      n_fail++;
      $display("FAIL latency3: got %0d cycles pulse=%b, want 7 cycles pulse=1000",
               lat, toggle_pulse);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (toggle_pulse != 4'b0000 || any_pulse) seen = 1'b1;
    end
    n_vec++;
    if (seen || btn_level !== 4'b1000) begin
      n_fail++;
      $display("FAIL held3: got extra_pulse=%b level=%b, want extra_pulse=0 level=1000",
               seen, btn_level);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
